mem_dados_param: RTL
====================

Name: mem_dados_param

Overview:
- Parametrised successor to the nRisc data memory: single-port synchronous RAM with configurable data width, depth and read latency.
- Adds a req/ready/rvalid handshake and a hardware clear sequencer that zeroes every word after reset.
- Sits between the datapath load/store stage and the control unit; the controller stalls on ready=0.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 8, address width; depth = 2**ADDR_W words
READ_LAT, 1, cycles from read accept edge to rvalid; legal range 1..15
CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = skip clear (contents undefined after power-up, retained across reset)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req  input  1  access request, sampled at posedge while ready=1
we  input  1  1 = write, 0 = read; qualified by req
addr  input  ADDR_W  word address
wdata  input  DATA_W  write data
rdata  output  DATA_W  read data; valid when rvalid=1, held otherwise
rvalid  output  1  one-cycle pulse marking read completion
ready  output  1  block can accept req this cycle
clearing  output  1  clear sequence in progress

Behaviour:
- Reset (async assert, any time): rdata=0, rvalid=0, ready=0, clearing=CLEAR_ON_RESET, ptr=0, lat counter=0, any pending read dropped. The state goes to CLEAR, or to IDLE if CLEAR_ON_RESET=0.
- FSM states: CLEAR, IDLE, RWAIT.
- CLEAR:
  - At each posedge, mem[ptr]<=0 and ptr<=ptr+1.
  - After writing address 2**ADDR_W-1, go to IDLE. This takes exactly 2**ADDR_W edges after reset release.
  - ready=0 and clearing=1 throughout; req is ignored.
- IDLE:
  - ready=1, clearing=0.
  - req&we at a posedge: mem[addr]<=wdata. Stay in IDLE with no rvalid, so back-to-back writes run every cycle.
  - req&!we at a posedge (accept edge k): latch addr, load counter=READ_LAT-1, go to RWAIT (ready=0 from edge k). The exception is READ_LAT=1, which completes directly (see below).
- RWAIT:
  - ready=0. The counter decrements at each posedge.
  - At edge k+READ_LAT: rdata<=mem[latched addr], rvalid<=1, ready<=1, return to IDLE.
  - rvalid is high for exactly the cycle after edge k+READ_LAT. In that same cycle ready=1, so a new req is accepted at edge k+READ_LAT+1.
  - For READ_LAT=1: the accept edge goes straight to a one-cycle completion. rvalid and ready=0 both hold in the cycle after edge k, and ready returns to 1 the following cycle. So max read throughput is 1 per READ_LAT+1 cycles.
- req while ready=0: ignored entirely. There is no queuing, no memory write, and addr/wdata are not captured.
- Read address snapshot: addr changes after the accept edge do not affect the result.
- Read-after-write: a write at edge k followed by a read accepted at edge k+1 returns the new data.
- Address wrap: addr is exactly ADDR_W bits, so no out-of-range case exists. ptr wraps to 0 when CLEAR ends.
- rdata holds its last completed value until the next read completes; reset zeroes it.
- Reset during RWAIT or CLEAR: the read is lost with no rvalid, and the clear restarts from address 0.
- With CLEAR_ON_RESET=0, ready=1 in the first cycle after reset release.

Test Plan:
- Clear: DATA_W=8, ADDR_W=4, CLEAR_ON_RESET=1. Preload with writes, reset, release. Required: clearing=1 and ready=0 for exactly 16 cycles; then reading all 16 addresses returns 0x00.
- Write/read, READ_LAT=1: write 0xA5 to address 0x3C, then read 0x3C. Required: rvalid pulses 1 cycle after the accept edge with rdata=0xA5; ready=0 that cycle and 1 the next.
- Latency 3: READ_LAT=3, mem[7]=0x5A, read address 7 accepted at edge k. Required: ready=0 for cycles k..k+2; rvalid=1 only in the cycle after edge k+3 with rdata=0x5A; a new read is accepted at edge k+4.
- Busy ignore: during RWAIT, drive req=1, we=1, addr=7, wdata=0xFF. Required: no write occurs; a later read of address 7 returns the old value 0x5A.
- Back-to-back writes then read: write 0x11, 0x22, 0x33 to addresses 0, 1, 2 on consecutive edges; change addr to 9 immediately after the read accept of address 1. Required: rdata=0x22.
- Reset mid-read: READ_LAT=4, assert reset 2 cycles after accept. Required: rvalid never asserts, rdata=0, and the clear sequence restarts from address 0.

Source files
------------

// File: rtl/mem_dados_param.sv
// Parametrised single-port data memory with a req/ready/rvalid handshake,
// a configurable read latency and a clear sequencer that zeroes every word after reset.
module mem_dados_param #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o,
  output logic              ready_o,
  output logic              clearing_o
);

  typedef enum logic [1:0] {CLEAR, IDLE, RWAIT} state_e;

  localparam int              DEPTH     = 2 ** ADDR_W;
  localparam logic [3:0]      LAT_M1    = 4'(READ_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] readAddr_q;
  logic [3:0]        cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;

  logic              memWe_d;
  logic [ADDR_W-1:0] memAddr_d;
  logic [DATA_W-1:0] memData_d;

  // The clear sequencer and host writes share the single write port.
  always_comb begin
    memWe_d   = 1'b0;
    memAddr_d = addr_i;
    memData_d = wdata_i;
    if (state_q == CLEAR) begin
      memWe_d   = 1'b1;
      memAddr_d = ptr_q;
      memData_d = '0;
    end else if (state_q == IDLE && req_i && we_i) begin
      memWe_d = 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (memWe_d && !reset_i) begin
      mem[memAddr_d] <= memData_d;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      ptr_q      <= '0;
      readAddr_q <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        CLEAR: begin
          ptr_q <= ptr_q + ADDR_W'(1);
          if (ptr_q == LAST_ADDR) begin
            state_q <= IDLE;
          end
        end
        IDLE: begin
          if (req_i && !we_i) begin
            readAddr_q <= addr_i;
            cnt_q      <= LAT_M1;
            state_q    <= RWAIT;
            // Single-cycle latency reads at the accept edge; RWAIT then only blocks one cycle.
            if (READ_LAT == 1) begin
              rdata_q  <= mem[addr_i];
              rvalid_q <= 1'b1;
            end
          end
        end
        RWAIT: begin
          if (READ_LAT == 1) begin
            state_q <= IDLE;
          end else if (cnt_q == 4'd0) begin
            rdata_q  <= mem[readAddr_q];
            rvalid_q <= 1'b1;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdata_o    = rdata_q;
  assign rvalid_o   = rvalid_q;
  assign ready_o    = (state_q == IDLE) && !reset_i;
  assign clearing_o = (state_q == CLEAR);

endmodule
